// File: rtl/ins_step_ctrl.sv
// Instruction register and micro-step counter for the multicycle control path.
// Optional SINGLE_STEP_EN adds a Step input that gates FETCH/EXEC advancement.
module ins_step_ctrl #(
    parameter int CNT_W    = 3,
    parameter int MAX_STEP = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [15:0]      MemData,
    input  logic             Buff_PC,
`ifdef SINGLE_STEP_EN
    input  logic             Step,
`endif
    output logic [CNT_W-1:0] Cnt,
    output logic [4:0]       InsM,
    output logic [1:0]       InsL,
    output logic [15:0]      IR,
    output logic             Fetch,
    output logic             Halted,
    output logic             StepErr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_STEP);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [15:0]      ir_r;
    logic             fetch_r;
    logic             halted_r;
    logic             step_err_r;
    logic             step_en_s;

    // HLT shares its opcode field with OutR; only the low bits tell them apart.
    function automatic logic is_hlt(input logic [15:0] ir);
        return (ir[15:11] == 5'b11100) && (ir[1:0] == 2'b01);
    endfunction

`ifdef SINGLE_STEP_EN
    assign step_en_s = Step;
`else
    assign step_en_s = 1'b1;
`endif

    // Control FSM; Fetch/Halted flags are registered alongside the state they decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            ir_r       <= 16'h0000;
            fetch_r    <= 1'b0;
            halted_r   <= 1'b0;
            step_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (Start) begin
                        state_r <= ST_FETCH;
                        fetch_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (step_en_s) begin
                        ir_r    <= MemData;
                        cnt_r   <= CNT_ONE;
                        state_r <= ST_EXEC;
                        fetch_r <= 1'b0;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_EXEC: begin
                    if (!step_en_s) begin
                        state_r <= ST_EXEC;
                    end else if (Buff_PC && is_hlt(ir_r)) begin
                        state_r  <= ST_HALT;
                        cnt_r    <= CNT_ZERO;
                        halted_r <= 1'b1;
                    end else if (Buff_PC) begin
                        state_r <= ST_FETCH;
                        cnt_r   <= CNT_ZERO;
                        fetch_r <= 1'b1;
                    end else if (cnt_r == CNT_MAX) begin
                        // Overrun: flag it and force a fresh fetch instead of wrapping.
                        step_err_r <= 1'b1;
                        state_r    <= ST_FETCH;
                        cnt_r      <= CNT_ZERO;
                        fetch_r    <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_HALT: begin
                    if (Start) begin
                        state_r  <= ST_FETCH;
                        halted_r <= 1'b0;
                        fetch_r  <= 1'b1;
                    end else begin
                        state_r <= ST_HALT;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    cnt_r    <= CNT_ZERO;
                    fetch_r  <= 1'b0;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    assign Cnt     = cnt_r;
    assign IR      = ir_r;
    assign InsM    = ir_r[15:11];
    assign InsL    = ir_r[1:0];
    assign Fetch   = fetch_r;
    assign Halted  = halted_r;
    assign StepErr = step_err_r;

endmodule

// File: tb/tb_ins_step_ctrl.sv
// Self-checking bench for ins_step_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_ins_step_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Start;
    logic [15:0] MemData;
    logic        Buff_PC;
    logic        Step;
    logic [2:0]  Cnt;
    logic [4:0]  InsM;
    logic [1:0]  InsL;
    logic [15:0] IR;
    logic        Fetch;
    logic        Halted;
    logic        StepErr;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_EXEC  = 2;
    localparam int M_HALT  = 3;
    localparam int MAXS    = 7;

    int          m_mode = M_IDLE;
    int          m_cnt  = 0;
    logic [15:0] m_ir   = 16'h0000;
    bit          m_err  = 1'b0;

    ins_step_ctrl #(.CNT_W(3), .MAX_STEP(7)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Start   (Start),
        .MemData (MemData),
        .Buff_PC (Buff_PC),
`ifdef SINGLE_STEP_EN
        .Step    (Step),
`endif
        .Cnt     (Cnt),
        .InsM    (InsM),
        .InsL    (InsL),
        .IR      (IR),
        .Fetch   (Fetch),
        .Halted  (Halted),
        .StepErr (StepErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: advances on each rising edge from the sampled inputs.
    always @(posedge clk) begin
        bit adv;
`ifdef SINGLE_STEP_EN
        adv = Step;
`else
        adv = 1'b1;
`endif
        if (!rst_n) begin
            m_mode = M_IDLE; m_cnt = 0; m_ir = 16'h0000; m_err = 1'b0;
        end else if ((m_mode == M_IDLE || m_mode == M_HALT) && Start) begin
            m_mode = M_FETCH;
        end else if (m_mode == M_FETCH && adv) begin
            m_ir = MemData; m_cnt = 1; m_mode = M_EXEC;
        end else if (m_mode == M_EXEC && adv) begin
            if (Buff_PC && m_ir[15:11] == 5'd28 && m_ir[1:0] == 2'd1) begin
                m_mode = M_HALT; m_cnt = 0;
            end else if (Buff_PC) begin
                m_mode = M_FETCH; m_cnt = 0;
            end else if (m_cnt == MAXS) begin
                m_err = 1'b1; m_mode = M_FETCH; m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cnt",     32'(Cnt),     32'(m_cnt));
            chk("ir",      32'(IR),      32'(m_ir));
            chk("insm",    32'(InsM),    32'(m_ir[15:11]));
            chk("insl",    32'(InsL),    32'(m_ir[1:0]));
            chk("fetch",   32'(Fetch),   32'(m_mode == M_FETCH));
            chk("halted",  32'(Halted),  32'(m_mode == M_HALT));
            chk("steperr", 32'(StepErr), 32'(m_err));
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; Start = 1'b0; MemData = 16'h0000; Buff_PC = 1'b0; Step = 1'b1;
        cyc(2);
        cmp_en = 1'b1;
        rst_n  = 1'b1;

        // ADD: Cnt 0,1,2,3,0 with Fetch on both step-0 cycles
        Start = 1'b1;
        cyc(1);
        chk("add_fetch0", 32'(Fetch), 32'd1);
        chk("add_cnt0",   32'(Cnt),   32'd0);
        Start = 1'b0; MemData = 16'h0000;
        for (int k = 1; k <= 3; k++) begin
            cyc(1);
            chk("add_cnt", 32'(Cnt), 32'(k));
        end
        Buff_PC = 1'b1;
        cyc(1);
        chk("add_cnt_end",   32'(Cnt),   32'd0);
        chk("add_fetch_end", 32'(Fetch), 32'd1);
        chk("add_insm",      32'(InsM),  32'd0);
        chk("add_insl",      32'(InsL),  32'd0);
        Buff_PC = 1'b0;

        // HLT: park, then restart with Start
        MemData = 16'hE001;
        cyc(1);
        chk("hlt_ir",   32'(IR),   32'hE001);
        chk("hlt_insm", 32'(InsM), 32'h1C);
        chk("hlt_insl", 32'(InsL), 32'h1);
        cyc(1);
        Buff_PC = 1'b1;
        cyc(1);
        chk("hlt_halted", 32'(Halted), 32'd1);
        chk("hlt_cnt",    32'(Cnt),    32'd0);
        Buff_PC = 1'b0;
        cyc(1);
        chk("hlt_hold", 32'(Halted), 32'd1);
        Start = 1'b1;
        cyc(1);
        chk("hlt_restart_fetch",  32'(Fetch),  32'd1);
        chk("hlt_restart_halted", 32'(Halted), 32'd0);
        Start = 1'b0;

        // OutR: same opcode field, not HLT
        MemData = 16'hE000;
        cyc(2);
        Buff_PC = 1'b1;
        cyc(1);
        chk("outr_fetch",  32'(Fetch),  32'd1);
        chk("outr_halted", 32'(Halted), 32'd0);
        Buff_PC = 1'b0;

        // Overrun: Cnt 1..7 then forced fetch with sticky StepErr
        MemData = 16'h1234;
        for (int k = 1; k <= 7; k++) begin
            cyc(1);
            chk("ovr_cnt", 32'(Cnt), 32'(k));
        end
        cyc(1);
        chk("ovr_cnt0",  32'(Cnt),     32'd0);
        chk("ovr_err",   32'(StepErr), 32'd1);
        chk("ovr_fetch", 32'(Fetch),   32'd1);
        MemData = 16'h0000;
        cyc(1);
        Buff_PC = 1'b1;
        cyc(1);
        chk("ovr_err_sticky", 32'(StepErr), 32'd1);
        Buff_PC = 1'b0;

        // Reset mid-EXEC at Cnt=3
        MemData = 16'hABCD;
        cyc(3);
        chk("rst_pre_cnt", 32'(Cnt), 32'd3);
        rst_n = 1'b0;
        cyc(2);
        chk("rst_cnt",    32'(Cnt),     32'd0);
        chk("rst_ir",     32'(IR),      32'h0000);
        chk("rst_fetch",  32'(Fetch),   32'd0);
        chk("rst_halted", 32'(Halted),  32'd0);
        chk("rst_err",    32'(StepErr), 32'd0);
        rst_n = 1'b1;
        cyc(1);
        chk("rst_idle", 32'(Fetch), 32'd0);

`ifdef SINGLE_STEP_EN
        // Step gating: hold at Cnt=2 for three cycles, then advance once
        Start = 1'b1;
        cyc(1);
        Start = 1'b0; MemData = 16'h5555;
        cyc(2);
        Step = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("step_hold_cnt", 32'(Cnt), 32'd2);
            chk("step_hold_ir",  32'(IR),  32'h5555);
        end
        Step = 1'b1;
        cyc(1);
        chk("step_adv_cnt", 32'(Cnt), 32'd3);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst_n   = ($urandom_range(0, 199) != 0);
            Start   = ($urandom_range(0, 3) == 0);
            Buff_PC = ($urandom_range(0, 5) == 0);
            Step    = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       MemData = 16'hE001;
                1:       MemData = 16'hE000;
                default: MemData = 16'($urandom);
            endcase
            cyc(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
